// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with a two-stage registered pipeline.
// Stage 1 issues the RAM read request; stage 2 presents the matching video and sync outputs.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       rd_req,
   output logic [9:0] rd_x,
   output logic [9:0] rd_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       line_start,
   output logic       frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SS    = H_ACTIVE + H_FP;
   localparam int V_SS    = V_ACTIVE + V_FP;
   logic [9:0] h_cnt, v_cnt;
   logic       hs_raw, vs_raw;
   logic       h_end, v_end, act, h_win, v_win;
   always_comb begin
      h_end = h_cnt == 10'(H_TOTAL - 1);
      v_end = v_cnt == 10'(V_TOTAL - 1);
      act   = h_cnt < 10'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
      h_win = h_cnt >= 10'(H_SS) && h_cnt < 10'(H_SS + H_SYNC);
      v_win = v_cnt >= 10'(V_SS) && v_cnt < 10'(V_SS + V_SYNC);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         rd_req      <= 1'b0;
         rd_x        <= '0;
         rd_y        <= '0;
         hs_raw      <= 1'b0;
         vs_raw      <= 1'b0;
         video_on    <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         h_cnt       <= h_end ? '0 : h_cnt + 10'd1;
         v_cnt       <= !h_end ? v_cnt : v_end ? '0 : v_cnt + 10'd1;
         rd_req      <= act;
         rd_x        <= act ? h_cnt : '0;
         rd_y        <= act ? v_cnt : '0;
         hs_raw      <= h_win;
         vs_raw      <= v_win;
         video_on    <= rd_req;
         pix_x       <= rd_x;
         pix_y       <= rd_y;
         hsync       <= hs_raw ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_raw ? SYNC_POL : ~SYNC_POL;
         line_start  <= rd_req && rd_x == '0;
         frame_start <= rd_req && rd_x == '0 && rd_y == '0;
      end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table plus positional model for a default and a shrunken raster.
module tb_vga_timing_gen;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
   logic       d_rd_req, d_hsync, d_vsync, d_video_on, d_ls, d_fs;
   logic [9:0] d_rd_x, d_rd_y, d_pix_x, d_pix_y;
   logic       s_rd_req, s_hsync, s_vsync, s_video_on, s_ls, s_fs;
   logic [9:0] s_rd_x, s_rd_y, s_pix_x, s_pix_y;
   logic [19:0] ram_d, ram_s;
   logic [45:0] d_out, s_out;
   int k = 0, checks = 0, errors = 0;
   bit stats = 1'b0;
   int fs1 = 0, fs2 = 0, sls = 0, svs = 0, maxy = 0, dhl = 0, dls = 0;
   typedef struct { int e; logic rd, vo; int px, py; logic hs, vs, ls, fs; } vec_t;
   vec_t tbl[13];

   always #5 clk = ~clk;

   vga_timing_gen dut_d (
      .clk(clk), .rst_n(rst_n), .en(en), .rd_req(d_rd_req), .rd_x(d_rd_x), .rd_y(d_rd_y),
      .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on), .pix_x(d_pix_x), .pix_y(d_pix_y),
      .line_start(d_ls), .frame_start(d_fs));

   // Tiny raster (16x8 totals, active-high syncs) so whole frames fit in a short run
   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n), .en(en), .rd_req(s_rd_req), .rd_x(s_rd_x), .rd_y(s_rd_y),
      .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on), .pix_x(s_pix_x), .pix_y(s_pix_y),
      .line_start(s_ls), .frame_start(s_fs));

   assign d_out = {d_rd_req, d_rd_x, d_rd_y, d_hsync, d_vsync, d_video_on, d_pix_x, d_pix_y, d_ls, d_fs};
   assign s_out = {s_rd_req, s_rd_x, s_rd_y, s_hsync, s_vsync, s_video_on, s_pix_x, s_pix_y, s_ls, s_fs};

   always_ff @(posedge clk)
      if (en) begin
         ram_d <= {d_rd_y, d_rd_x};
         ram_s <= {s_rd_y, s_rd_x};
      end

   function automatic logic [22:0] at_pos(int p, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
      int ht = ha + hf + hs + hb;
      int vt = va + vf + vs + vb;
      int h = p % ht;
      int v = (p / ht) % vt;
      logic a = h < ha && v < va;
      return {a, a ? 10'(h) : 10'd0, a ? 10'(v) : 10'd0,
              h >= ha + hf && h < ha + hf + hs, v >= va + vf && v < va + vf + vs};
   endfunction

   // Expected outputs after k enabled edges: request shows position k-1, video shows k-2
   function automatic logic [45:0] model(int kk, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb, logic pol);
      logic [22:0] s1 = kk >= 1 ? at_pos(kk - 1, ha, hf, hs, hb, va, vf, vs, vb) : 23'd0;
      logic [22:0] s2 = kk >= 2 ? at_pos(kk - 2, ha, hf, hs, hb, va, vf, vs, vb) : 23'd0;
      logic ls = s2[22] && s2[21:12] == 10'd0;
      return {s1[22:2], s2[1] ? pol : ~pol, s2[0] ? pol : ~pol, s2[22:2], ls, ls && s2[11:2] == 10'd0};
   endfunction

   function automatic logic [45:0] model_d(int kk);
      return model(kk, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic logic [45:0] model_s(int kk);
      return model(kk, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1);
   endfunction

   task automatic chk(string name, logic [45:0] act, logic [45:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
      end
   endtask

   task automatic step();
      logic e = en;
      @(posedge clk);
      #1;
      if (e) k++;
      chk("dflt_model", d_out, model_d(k));
      chk("small_model", s_out, model_s(k));
      if (d_video_on) chk("ram_dflt", 46'(ram_d), 46'({d_pix_y, d_pix_x}));
      if (s_video_on) chk("ram_small", 46'(ram_s), 46'({s_pix_y, s_pix_x}));
      if (stats) begin
         if (s_fs) begin
            if (fs1 == 0) fs1 = k;
            else if (fs2 == 0) fs2 = k;
         end
         if (fs1 != 0 && fs2 == 0) begin
            sls += int'(s_ls);
            svs += int'(s_vsync);
         end
         if (s_video_on && int'(s_pix_y) > maxy) maxy = int'(s_pix_y);
         if (k >= 2 && k <= 801 && !d_hsync) dhl++;
         dls += int'(d_ls);
      end
   endtask

   task automatic run_table();
      for (int i = 0; i < 13; i++) begin
         while (k < tbl[i].e) step();
         chk($sformatf("table_e%0d", tbl[i].e),
             46'({d_rd_req, d_video_on, d_pix_x, d_pix_y, d_hsync, d_vsync, d_ls, d_fs}),
             46'({tbl[i].rd, tbl[i].vo, 10'(tbl[i].px), 10'(tbl[i].py), tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs}));
      end
   endtask

   initial begin
      tbl = '{'{1,    1, 0, 0,   0, 1, 1, 0, 0},
              '{2,    1, 1, 0,   0, 1, 1, 1, 1},
              '{3,    1, 1, 1,   0, 1, 1, 0, 0},
              '{641,  0, 1, 639, 0, 1, 1, 0, 0},
              '{642,  0, 0, 0,   0, 1, 1, 0, 0},
              '{657,  0, 0, 0,   0, 1, 1, 0, 0},
              '{658,  0, 0, 0,   0, 0, 1, 0, 0},
              '{753,  0, 0, 0,   0, 0, 1, 0, 0},
              '{754,  0, 0, 0,   0, 1, 1, 0, 0},
              '{801,  1, 0, 0,   0, 1, 1, 0, 0},
              '{802,  1, 1, 0,   1, 1, 1, 1, 0},
              '{803,  1, 1, 1,   1, 1, 1, 0, 0},
              '{1442, 0, 0, 0,   0, 1, 1, 0, 0}};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dflt", d_out, model_d(0));
      chk("reset_small", s_out, model_s(0));
      rst_n = 1'b1;
      stats = 1'b1;
      run_table();
      while (k < 2000) step();
      stats = 1'b0;
      chk("small_fs_first", 46'(fs1), 46'd2);
      chk("small_fs_second", 46'(fs2), 46'd130);
      chk("small_ls_per_frame", 46'(sls), 46'd4);
      chk("small_vsync_cycles", 46'(svs), 46'd32);
      chk("small_max_y", 46'(maxy), 46'd3);
      chk("dflt_hsync_low", 46'(dhl), 46'd96);
      chk("dflt_ls_count", 46'(dls), 46'd3);
      repeat (600) begin
         en = 1'($urandom_range(0, 1));
         step();
      end
      en = 1'b1;
      step();
      rst_n = 1'b0;
      #1;
      chk("async_reset_dflt", d_out, model_d(0));
      chk("async_reset_small", s_out, model_s(0));
      repeat (2) @(posedge clk);
      #1;
      chk("held_reset_dflt", d_out, model_d(0));
      rst_n = 1'b1;
      k = 0;
      run_table();
      repeat (200) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
